usrt_rx_front: RTL and testbench
================================

Name: usrt_rx_front

Overview:
Receive front end of the USRT. It combines a programmable baud-clock generator with a start-bit-triggered receive shift register. The generator derives the serial bit clock o_Bclk from the system clock i_Pclk. The shifter samples i_Rx_Serial at mid-bit, assembles a frame of up to 11 bits LSB-first, and presents the frame with a one-cycle done strobe to the downstream USRT control logic.

Parameters:
DATA_W, 11, maximum frame length in bits (start + data + parity + stop)
BAUD_W, 14, width of the baud divisor input
CNT_W, 4, width of the frame-length input

Ports:
i_Pclk  input  1  system clock, all logic on rising edge
i_Rst_n  input  1  asynchronous active-low reset
i_Baud  input  BAUD_W  half-period of o_Bclk in i_Pclk cycles
i_Enable  input  1  receiver enable
i_Count  input  CNT_W  frame length in bits, start bit included
i_Rx_Serial  input  1  serial data, idle high, changes on o_Bclk rising edge
o_Bclk  output  1  bit clock
o_Data  output  DATA_W  last received frame, bit n = nth bit received
o_Done  output  1  one-cycle pulse when o_Data is updated

Behaviour:
- One clock (i_Pclk). Reset is asynchronous and active-low on i_Rst_n. Reset values: o_Bclk=0, o_Data=0, o_Done=0, FSM=IDLE, all counters=0.
- Baud divider:
  - 14-bit counter increments every i_Pclk cycle.
  - When the counter equals i_Baud-1, it clears and o_Bclk toggles.
  - o_Bclk period is 2*i_Baud cycles at 50% duty. First rise occurs i_Baud cycles after reset release.
  - i_Baud=0: counter and o_Bclk held at 0.
  - i_Baud change mid-count: a counter at or above the new i_Baud-1 wraps at the next cycle.
- Sample strobe (internal):
  - One-cycle pulse asserted in the cycle the divider toggles o_Bclk from 1 to 0 (mid-bit).
  - i_Rx_Serial is sampled on that clock edge.
  - No synchronizer: the input is source-synchronous to o_Bclk.
- Frame length: i_Count is latched at start-bit detection. Values 0 or greater than 11 are treated as 11. Latched length is L.
- FSM:
  - IDLE: on strobe with i_Enable=1 and i_Rx_Serial=0 (start bit), clear the shift register, store bit0=0, set bit index=1, latch L, go to SHIFT. If L=1, complete immediately (see SHIFT).
  - SHIFT: on each strobe, store i_Rx_Serial at the bit-index position and increment the index. On the strobe that stores bit L-1:
    - copy the shift register to o_Data, with bits L..10 forced to 0;
    - assert o_Done for exactly one cycle on that same edge;
    - return to IDLE.
  - The next start bit can be detected on the following strobe.
  - i_Enable=0 in any state: FSM returns to IDLE next cycle, partial frame is discarded, no o_Done, o_Data unchanged.
  - i_Rx_Serial=1 on strobe in IDLE: remain in IDLE.
- o_Data holds its value between frames. It changes only together with o_Done.
- No parity or stop-bit checking here; that is the downstream block's job.
- Reset asserted mid-frame: immediate return to reset values.

Decomposition:
- Package usrt_pkg:
  - DATA_W, BAUD_W, CNT_W;
  - MAX_BITS=11;
  - FSM state enum {IDLE, SHIFT}.
- One sub-module: usrt_baud_div (divider plus o_Bclk plus sample strobe).
- Top usrt_rx_front instantiates usrt_baud_div and holds the FSM and shift register.

Test Plan:
1. Reset, i_Baud=87, i_Enable=0 -> o_Bclk period 174 cycles, high 87, first rise 87 cycles after reset release; o_Data=0, o_Done=0.
2. i_Enable=1, i_Count=11, drive 11'b10100011010 LSB-first, each bit changed on o_Bclk rise and held 174 cycles -> exactly one o_Done pulse at the 11th sample; o_Data=11'h51A.
3. Same frame with i_Enable=0 -> no o_Done; o_Data stays 0.
4. i_Count=8, drive 8'hAA LSB-first, line then idle high -> o_Done once; o_Data=11'h0AA; no further o_Done while the line idles high.
5. After test 2, drop i_Enable after 5 bits, then re-enable and send 11'b10100011010 -> no o_Done for the aborted frame and o_Data stays 11'h51A; second frame gives o_Done with 11'h51A.
6. i_Baud=0 -> o_Bclk constant 0, no strobes. Async i_Rst_n pulse mid-frame -> o_Bclk, o_Data, o_Done clear at once; frame discarded.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared constants, FSM state type and frame-length helpers for the USRT receive path.
package usrt_pkg;
  localparam int DATA_W   = 11;
  localparam int BAUD_W   = 14;
  localparam int CNT_W    = 4;
  localparam int MAX_BITS = 11;

  typedef enum logic {IDLE, SHIFT} state_e;

  // Out-of-range lengths (0 or above MAX_BITS) fall back to a full frame.
  function automatic logic [CNT_W-1:0] frame_len(input logic [CNT_W-1:0] c);
    if (c == '0 || c > CNT_W'(MAX_BITS)) return CNT_W'(MAX_BITS);
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] len_mask(input logic [CNT_W-1:0] l);
    logic [DATA_W:0] m;
    m = ({{DATA_W{1'b0}}, 1'b1} << l) - 1'b1;
    return m[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/usrt_baud_div.sv
// Programmable bit-clock divider; strobes mid-bit on the falling edge of o_Bclk.
module usrt_baud_div
  import usrt_pkg::*;
(
  input  logic              i_Pclk,
  input  logic              i_Rst_n,
  input  logic [BAUD_W-1:0] i_Baud,
  output logic              o_Bclk,
  output logic              o_Strobe
);
  logic [BAUD_W-1:0] cnt;
  logic              wrap;

  // >= so a shrinking divisor wraps immediately instead of running to rollover.
  assign wrap     = (i_Baud != '0) && (cnt >= i_Baud - 1'b1);
  assign o_Strobe = wrap & o_Bclk;

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt    <= '0;
      o_Bclk <= 1'b0;
    end else if (i_Baud == '0) begin
      cnt    <= '0;
      o_Bclk <= 1'b0;
    end else if (wrap) begin
      cnt    <= '0;
      o_Bclk <= ~o_Bclk;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/usrt_rx_front.sv
// USRT receive front end: baud divider plus start-bit-triggered LSB-first shift register.
module usrt_rx_front
  import usrt_pkg::*;
(
  input  logic              i_Pclk,
  input  logic              i_Rst_n,
  input  logic [BAUD_W-1:0] i_Baud,
  input  logic              i_Enable,
  input  logic [CNT_W-1:0]  i_Count,
  input  logic              i_Rx_Serial,
  output logic              o_Bclk,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Done
);
  state_e            state;
  logic              strobe;
  logic [CNT_W-1:0]  idx, len, len_in;
  logic [DATA_W-1:0] shreg, sh_nxt;

  usrt_baud_div u_baud (
    .i_Pclk   (i_Pclk),
    .i_Rst_n  (i_Rst_n),
    .i_Baud   (i_Baud),
    .o_Bclk   (o_Bclk),
    .o_Strobe (strobe)
  );

  assign len_in = frame_len(i_Count);

  always_comb begin
    sh_nxt = shreg;
    if (idx < CNT_W'(DATA_W)) sh_nxt[idx] = i_Rx_Serial;
  end

  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      len    <= '0;
      shreg  <= '0;
      o_Data <= '0;
      o_Done <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      if (!i_Enable) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: if (strobe && !i_Rx_Serial) begin
            shreg <= '0;
            idx   <= CNT_W'(1);
            len   <= len_in;
            // A one-bit frame is just the start bit: complete on detection.
            if (len_in == CNT_W'(1)) begin
              o_Data <= '0;
              o_Done <= 1'b1;
            end else begin
              state  <= SHIFT;
            end
          end
          SHIFT: if (strobe) begin
            shreg <= sh_nxt;
            idx   <= idx + 1'b1;
            if (idx == len - 1'b1) begin
              o_Data <= sh_nxt & len_mask(len);
              o_Done <= 1'b1;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usrt_rx_front.sv
// Directed bench for usrt_rx_front: bit-clock timing, frame capture, abort, reset.
module tb_usrt_rx_front;
  logic        i_Pclk = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic [13:0] i_Baud = 14'd87;
  logic        i_Enable = 1'b0;
  logic [3:0]  i_Count = 4'd11;
  logic        i_Rx_Serial = 1'b1;
  logic        o_Bclk;
  logic [10:0] o_Data;
  logic        o_Done;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int data_bad = 0;
  logic [10:0] prev_data = '0;

  usrt_rx_front dut (
    .i_Pclk      (i_Pclk),
    .i_Rst_n     (i_Rst_n),
    .i_Baud      (i_Baud),
    .i_Enable    (i_Enable),
    .i_Count     (i_Count),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Bclk      (o_Bclk),
    .o_Data      (o_Data),
    .o_Done      (o_Done)
  );

  always #5 i_Pclk = ~i_Pclk;

  // Done pulses are counted per cycle, so a stretched pulse shows as an extra count.
  always @(negedge i_Pclk) begin
    if (o_Done === 1'b1) done_cnt++;
    if (i_Rst_n && o_Data !== prev_data && o_Done !== 1'b1) data_bad++;
    prev_data = o_Data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rise();
    logic p;
    p = o_Bclk;
    for (int n = 0; n < 400; n++) begin
      @(posedge i_Pclk); #1;
      if (!p && o_Bclk) return;
      p = o_Bclk;
    end
    vectors++;
    miscompares++;
    $error("FAIL bclk_timeout: observed no rise expected rise within 400 cycles");
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      wait_rise();
      i_Rx_Serial = bits[i];
    end
  endtask

  task automatic send_frame(input logic [10:0] bits, input int n);
    send_bits(bits, n);
    wait_rise();
    i_Rx_Serial = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge i_Pclk);
    #1;
  endtask

  initial begin
    int k, d0, hi;
    // 1: reset state and bit-clock timing
    idle_cycles(3);
    check("rst_data", 32'(o_Data), 32'h0);
    check("rst_done", 32'(o_Done), 32'h0);
    check("rst_bclk", 32'(o_Bclk), 32'h0);
    i_Rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge i_Pclk); #1; k++;
      if (o_Bclk) break;
    end
    check("first_rise", 32'(k), 32'd87);
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge i_Pclk); #1; k++;
      if (!o_Bclk) break;
    end
    check("bclk_high", 32'(k), 32'd87);
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge i_Pclk); #1; k++;
      if (o_Bclk) break;
    end
    check("bclk_low", 32'(k), 32'd87);

    // 3: disabled receiver ignores a full frame
    d0 = done_cnt;
    send_frame(11'b10100011010, 11);
    idle_cycles(200);
    check("dis_done", 32'(done_cnt - d0), 32'd0);
    check("dis_data", 32'(o_Data), 32'h0);

    // 2: full 11-bit frame
    i_Enable = 1'b1;
    d0 = done_cnt;
    send_frame(11'b10100011010, 11);
    idle_cycles(200);
    check("f11_done", 32'(done_cnt - d0), 32'd1);
    check("f11_data", 32'(o_Data), 32'h51A);

    // 5: abort after 5 bits, then a clean frame
    d0 = done_cnt;
    send_bits(11'b10100011010, 5);
    wait_rise();
    i_Enable = 1'b0;
    i_Rx_Serial = 1'b1;
    idle_cycles(200);
    i_Enable = 1'b1;
    idle_cycles(200);
    check("abort_done", 32'(done_cnt - d0), 32'd0);
    check("abort_data", 32'(o_Data), 32'h51A);
    send_frame(11'b10100011010, 11);
    idle_cycles(200);
    check("reen_done", 32'(done_cnt - d0), 32'd1);
    check("reen_data", 32'(o_Data), 32'h51A);

    // i_Count=0 behaves as 11
    i_Count = 4'd0;
    d0 = done_cnt;
    send_frame(11'h2D4, 11);
    idle_cycles(200);
    check("c0_done", 32'(done_cnt - d0), 32'd1);
    check("c0_data", 32'(o_Data), 32'h2D4);

    // i_Count=1: start bit alone is a frame
    i_Count = 4'd1;
    d0 = done_cnt;
    send_frame(11'h000, 1);
    idle_cycles(200);
    check("c1_done", 32'(done_cnt - d0), 32'd1);
    check("c1_data", 32'(o_Data), 32'h0);

    // 4: 8-bit frame, upper bits masked, quiet on idle line
    i_Count = 4'd8;
    d0 = done_cnt;
    send_frame(11'h0AA, 8);
    idle_cycles(20);
    check("f8_done", 32'(done_cnt - d0), 32'd1);
    check("f8_data", 32'(o_Data), 32'h0AA);
    wait_rise(); wait_rise(); wait_rise();
    check("f8_idle_done", 32'(done_cnt - d0), 32'd1);

    // 6a: i_Baud=0 stops the bit clock and strobes
    i_Baud = 14'd0;
    i_Rx_Serial = 1'b0;
    idle_cycles(2);
    d0 = done_cnt;
    hi = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge i_Pclk); #1;
      if (o_Bclk !== 1'b0) hi++;
    end
    check("b0_bclk_high", 32'(hi), 32'd0);
    check("b0_done", 32'(done_cnt - d0), 32'd0);
    i_Rx_Serial = 1'b1;
    i_Baud = 14'd87;

    // 6b: async reset mid-frame
    i_Count = 4'd11;
    d0 = done_cnt;
    send_bits(11'b10100011010, 4);
    #53;
    check("pre_rst_bclk", 32'(o_Bclk), 32'h1);
    i_Rst_n = 1'b0;
    #1;
    check("arst_bclk", 32'(o_Bclk), 32'h0);
    check("arst_data", 32'(o_Data), 32'h0);
    check("arst_done", 32'(o_Done), 32'h0);
    #20;
    i_Rx_Serial = 1'b1;
    i_Rst_n = 1'b1;
    idle_cycles(2500);
    check("post_rst_done", 32'(done_cnt - d0), 32'd0);
    check("post_rst_data", 32'(o_Data), 32'h0);
    check("data_only_with_done", 32'(data_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
